// File: rtl/mux_arbiter4_pkg.sv
// mux_arbiter4_pkg: shared widths and FSM encoding for the round-robin mux arbiter
package mux_arbiter4_pkg;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int SEL_W   = 2;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/mux_arbiter4_if.sv
// mux_arbiter4_if: requester/consumer bundle of the mux arbiter
interface mux_arbiter4_if;
    import mux_arbiter4_pkg::*;
    logic [NUM_REQ-1:0] req;
    logic [DATA_W-1:0]  d0, d1, d2, d3;
    logic               out_ready;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic [DATA_W-1:0]  y;
    logic               out_valid;
    modport slave (input req, d0, d1, d2, d3, out_ready, output gnt, sel, y, out_valid);
    modport master (output req, d0, d1, d2, d3, out_ready, input gnt, sel, y, out_valid);
endinterface

// File: rtl/mux4_1.sv
// mux4_1: 8-bit 4:1 data multiplexer
module mux4_1 (
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [1:0] sel,
    output logic [7:0] y
);
    always_comb y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/mux_arbiter4.sv
// mux_arbiter4: round-robin arbiter with burst limit steering four requesters onto one output
module mux_arbiter4 import mux_arbiter4_pkg::*; #(
    parameter int unsigned MAX_BURST = 4
) (
    input logic clk,
    input logic rst,
    mux_arbiter4_if.slave bus
);
    state_t state, state_n;
    logic [NUM_REQ-1:0] gnt, gnt_n;
    logic [SEL_W-1:0] sel, sel_n, ptr, ptr_n, base, win;
    logic [3:0] cnt, cnt_n;
    logic found, xfer, rel;

    // Scan from the farthest slot down so the slot closest to p wins
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] i;
        rr_pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            i = p + SEL_W'(k);
            if (r[i]) rr_pick = {1'b1, i};
        end
    endfunction

    mux4_1 u_mux (
        .d0(bus.d0), .d1(bus.d1), .d2(bus.d2), .d3(bus.d3),
        .sel(sel), .y(bus.y)
    );

    assign bus.gnt = gnt;
    assign bus.sel = sel;
    assign bus.out_valid = (|gnt) && bus.req[sel];
    assign xfer = bus.out_valid && bus.out_ready;
    assign rel = (state == GRANT) && (!bus.req[sel] || (xfer && cnt == 4'(MAX_BURST - 1)));
    assign base = rel ? sel + 1'b1 : ptr;
    assign {found, win} = rr_pick(bus.req, base);

    always_comb begin
        state_n = state;
        gnt_n = gnt;
        sel_n = sel;
        ptr_n = ptr;
        cnt_n = cnt;
        if (state == IDLE || rel) begin
            ptr_n = base;
            state_n = found ? GRANT : IDLE;
            gnt_n = found ? 4'(1) << win : '0;
            sel_n = found ? win : sel;
            cnt_n = '0;
        end else if (xfer) begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            sel <= '0;
            ptr <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            sel <= sel_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_mux_arbiter4.sv
// tb_mux_arbiter4: scoreboard bench for the round-robin mux arbiter
module tb_mux_arbiter4;
    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;
    exp_t exp_q[$];
    logic [7:0] dv [4] = '{8'h10, 8'h21, 8'hA5, 8'h43};

    mux_arbiter4_if bus ();
    mux_arbiter4 #(.MAX_BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.d0 = dv[0];
    assign bus.d1 = dv[1];
    assign bus.d2 = dv[2];
    assign bus.d3 = dv[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic push(input int m, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.gnt = 4'(1) << m;
            e.y = dv[m];
            exp_q.push_back(e);
        end
    endtask

    // Inputs set before the call are the ones the consumer sees this cycle
    task automatic tick();
        exp_t e;
        #1;
        if (mon_en && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("extra_xfer", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("xfer_gnt", bus.gnt, e.gnt);
                check("xfer_y", bus.y, e.y);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        mon_en = 1'b0;
        bus.req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        bus.req = 4'b1111;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_gnt", bus.gnt, 4'b0000);
        check("rst_sel", bus.sel, 2'd0);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_y", bus.y, 8'h10);
        rst = 1'b0;
        tick();
        check("first_gnt", bus.gnt, 4'b0001);
        mon_en = 1'b1;
        bus.out_ready = 1'b1;
        for (int m = 0; m < 5; m++) push(m % 4, 4);
        for (int k = 0; k < 20; k++) tick();
        check("fair_drain", exp_q.size(), 0);
        check("fair_end_gnt", bus.gnt, 4'b0010);

        reset_dut();
        bus.req = 4'b0100;
        tick();
        check("single_gnt", bus.gnt, 4'b0100);
        check("single_y", bus.y, 8'hA5);
        for (int k = 0; k < 12; k++) begin
            push(2, 1);
            tick();
            check("single_cnt", dut.cnt, (k + 1) % 4);
        end
        check("single_drain", exp_q.size(), 0);

        reset_dut();
        bus.req = 4'b0010;
        tick();
        push(1, 2);
        tick();
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("bp_gnt", bus.gnt, 4'b0010);
        check("bp_cnt", dut.cnt, 2);
        check("bp_y", bus.y, 8'h21);
        bus.out_ready = 1'b1;
        push(1, 2);
        tick();
        tick();
        check("bp_drain", exp_q.size(), 0);
        check("bp_cnt_wrap", dut.cnt, 0);
        check("bp_regnt", bus.gnt, 4'b0010);

        reset_dut();
        bus.req = 4'b1010;
        tick();
        check("drop_gnt0", bus.gnt, 4'b0010);
        push(1, 2);
        tick();
        tick();
        bus.req = 4'b1000;
        #1;
        check("drop_valid", bus.out_valid, 1'b0);
        tick();
        check("drop_gnt", bus.gnt, 4'b1000);
        check("drop_ptr", dut.ptr, 2);
        push(3, 1);
        tick();
        check("drop_drain", exp_q.size(), 0);

        reset_dut();
        bus.req = 4'b0100;
        tick();
        push(2, 7);
        for (int k = 0; k < 6; k++) tick();
        check("mid_ptr", dut.ptr, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_gnt", bus.gnt, 4'b0000);
        check("mid_valid", bus.out_valid, 1'b0);
        check("mid_ptr_rst", dut.ptr, 0);
        check("mid_drain", exp_q.size(), 0);
        bus.req = 4'b1110;
        tick();
        check("post_gnt", bus.gnt, 4'b0010);
        check("post_sel", bus.sel, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mux_arbiter4.md
MUX_ARBITER4 -- requirements
Module: mux_arbiter4

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum transfers per grant (legal 1..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  input  4  request per requester i (bit i); held high while requester i has a word on d<i>.
REQ-005 SHALL have ports d0, d1, d2, d3  input  8 each  requester data words.
REQ-006 SHALL have port out_ready  input  1  consumer accepts y this cycle.
REQ-007 SHALL have port gnt  output  4  one-hot grant, registered; 0 when idle.
REQ-008 SHALL have port sel  output  2  registered index of the granted requester (mux select).
REQ-009 SHALL have port y  output  8  combinational, equal to d<sel>.
REQ-010 SHALL have port out_valid  output  1  combinational, equal to (gnt != 0) AND req[sel].

Function
REQ-011 SHALL implement FSM states IDLE and GRANT, plus a 2-bit round-robin pointer ptr and a 4-bit burst counter cnt.
REQ-012 A transfer SHALL occur in exactly the cycles where out_valid AND out_ready; requester sel treats the same cycle as acceptance of its word.
REQ-013 Arbitration SHALL select the first asserted req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 In IDLE with any req bit set, the FSM SHALL load gnt/sel with the arbitration winner, clear cnt, and enter GRANT next cycle; latency req->gnt is 1 cycle.
REQ-015 In IDLE with req == 0, the FSM SHALL stay in IDLE with gnt = 0; sel SHALL hold its last value.
REQ-016 In GRANT, each transfer SHALL increment cnt; cnt SHALL NOT change without a transfer.
REQ-017 Release SHALL occur in GRANT when req[sel] == 0, or when a transfer occurs with cnt == MAX_BURST-1.
REQ-018 On release, ptr SHALL become sel+1 (mod 4), so the releasing requester has lowest priority.
REQ-019 On release, arbitration over the current req with the updated ptr SHALL choose the next master; if any req bit is set, the FSM SHALL stay in GRANT, load the new gnt/sel, and clear cnt; otherwise it SHALL go to IDLE with gnt = 0.
REQ-020 A lone requester that releases on burst limit SHALL be re-granted with no idle cycle; out_valid stays continuous.
REQ-021 With out_ready held low, gnt, sel, cnt and y SHALL remain stable indefinitely; there is no timeout.
REQ-022 Changes to req bits other than req[sel] SHALL NOT affect the current grant.
REQ-023 gnt SHALL never have more than one bit set.

Reset
REQ-024 While rst = 1 at a clock edge, the block SHALL load state = IDLE, gnt = 0, sel = 0, ptr = 0, cnt = 0, regardless of req; out_valid is therefore 0 and y = d0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no further transfer from the next cycle; the first grant after reset SHALL follow REQ-014 with ptr = 0.

Structure
REQ-026 Constants SHALL live in a shared package: NUM_REQ = 4, DATA_W = 8, SEL_W = 2, state encoding IDLE = 0 and GRANT = 1.
REQ-027 The data path SHALL be one instance of the existing 8-bit 4:1 mux, mux4_1, driven by sel. All control logic (FSM, pointer, counter, round-robin priority function) SHALL be in mux_arbiter4.

Verification
REQ-028 Reset: rst = 1 with req = 1111 -> gnt = 0000, sel = 0, out_valid = 0; rst falls -> gnt = 0001 on the second edge.
REQ-029 Single requester: req = 0100, d2 = 0xA5, out_ready = 1 -> gnt = 0100 one cycle later, y = 0xA5, out_valid held high continuously, cnt wraps every 4 transfers.
REQ-030 Fairness: req = 1111, out_ready = 1 -> gnt sequence 0001, 0010, 0100, 1000, 0001, each for exactly 4 transfers with zero idle cycles.
REQ-031 Backpressure: out_ready = 0 for 10 cycles after the second transfer of master 1 -> gnt = 0010 and cnt = 2 stable; 2 more transfers complete the burst after out_ready returns.
REQ-032 Early drop: master 1 drops req after 2 transfers while req[3] = 1 -> out_valid = 0 in the drop cycle, gnt = 1000 next cycle, ptr = 2.
REQ-033 Reset mid-burst: rst pulsed during master 2's third transfer -> gnt = 0 next cycle; after release the first grant goes to the lowest set req index starting from 0.
